// File: rtl/fir_yout_gpio.sv
// FIR output (Yn) to GPIO check-field presenter: frames words between start/end markers.
// Optional 4-entry input FIFO enabled by defining FIR_YOUT_FIFO_EN.
//
// state   | meaning
// IDLE    | waiting for start_i, io_out holds last value
// START   | start marker on io_out for HOLD_CYCLES cycles
// DWAIT   | waiting for the next Yn word
// DHOLD   | data word on io_out for HOLD_CYCLES cycles
// END     | end marker on io_out for HOLD_CYCLES cycles, then frame_done
module fir_yout_gpio #(
    parameter int unsigned HOLD_CYCLES = 8,
    parameter logic [15:0] START_MARK  = 16'hAB40,
    parameter logic [15:0] END_MARK    = 16'hAB51
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic        sm_tvalid,
    input  logic [31:0] sm_tdata,
    input  logic        sm_tlast,
    output logic        sm_tready,
    output logic [15:0] io_out,
    output logic [15:0] io_oeb,
    output logic        word_stb,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DWAIT,
        S_DHOLD,
        S_END
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] io_out_q, io_out_d;
    logic [15:0] io_oeb_q, io_oeb_d;
    logic        word_stb_q, word_stb_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic        last_q, last_d;
    logic        sm_tready_q, tready_d;

    logic        src_valid;
    logic [15:0] src_data;
    logic        src_last;

    // Only the low half of Yn reaches the pads; the upper half is dropped on purpose.
    logic unused_hi;
    assign unused_hi = ^sm_tdata[31:16];

`ifdef FIR_YOUT_FIFO_EN
    localparam int unsigned FIFO_DEPTH = 4;

    logic [16:0] fifo_mem_q [FIFO_DEPTH];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  fifo_cnt_q, fifo_cnt_d;
    logic        push, pop;

    assign push      = sm_tvalid & sm_tready_q;
    assign pop       = (state_q == S_DWAIT) && src_valid;
    assign src_valid = (fifo_cnt_q != 3'd0);
    assign src_data  = fifo_mem_q[rd_ptr_q][15:0];
    assign src_last  = fifo_mem_q[rd_ptr_q][16];

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            fifo_cnt_q <= 3'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {sm_tlast, sm_tdata[15:0]};
    end

    // Ready comes from the next-cycle fill level, so a push can never land on a full FIFO.
    assign tready_d = (fifo_cnt_d != 3'(FIFO_DEPTH)) && (state_d != S_IDLE);
`else
    assign src_valid = sm_tvalid & sm_tready_q;
    assign src_data  = sm_tdata[15:0];
    assign src_last  = sm_tlast;
    assign tready_d  = (state_d == S_DWAIT);
`endif

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        io_out_d     = io_out_q;
        io_oeb_d     = io_oeb_q;
        word_stb_d   = 1'b0;
        frame_done_d = 1'b0;
        word_cnt_d   = word_cnt_q;
        last_d       = last_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_START;
                    hold_d     = HOLD_LOAD;
                    io_out_d   = START_MARK;
                    io_oeb_d   = 16'h0000;
                    word_cnt_d = 8'd0;
                    word_stb_d = 1'b1;
                end
            end
            S_START: begin
                if (hold_q == 8'd0) state_d = S_DWAIT;
                else                hold_d  = hold_q - 8'd1;
            end
            S_DWAIT: begin
                if (src_valid) begin
                    state_d    = S_DHOLD;
                    hold_d     = HOLD_LOAD;
                    io_out_d   = src_data;
                    word_stb_d = 1'b1;
                    last_d     = src_last;
                    word_cnt_d = (word_cnt_q == 8'hFF) ? word_cnt_q : word_cnt_q + 8'd1;
                end
            end
            S_DHOLD: begin
                if (hold_q != 8'd0) begin
                    hold_d = hold_q - 8'd1;
                end else if (last_q) begin
                    state_d    = S_END;
                    hold_d     = HOLD_LOAD;
                    io_out_d   = END_MARK;
                    word_stb_d = 1'b1;
                end else begin
                    state_d = S_DWAIT;
                end
            end
            S_END: begin
                if (hold_q == 8'd0) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            hold_q       <= 8'd0;
            io_out_q     <= 16'h0000;
            io_oeb_q     <= 16'hFFFF;
            word_stb_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            word_cnt_q   <= 8'd0;
            last_q       <= 1'b0;
            sm_tready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            io_out_q     <= io_out_d;
            io_oeb_q     <= io_oeb_d;
            word_stb_q   <= word_stb_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            word_cnt_q   <= word_cnt_d;
            last_q       <= last_d;
            sm_tready_q  <= tready_d;
        end
    end

    assign sm_tready  = sm_tready_q;
    assign io_out     = io_out_q;
    assign io_oeb     = io_oeb_q;
    assign word_stb   = word_stb_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_fir_yout_gpio.sv
// Self-checking bench for fir_yout_gpio (default build, HOLD_CYCLES=4).
// Table-driven short frames plus directed multi-cycle sequences.
module tb_fir_yout_gpio;

    localparam int H = 4;
    localparam logic [15:0] SM = 16'hAB40;
    localparam logic [15:0] EM = 16'hAB51;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        sm_tvalid = 1'b0;
    logic [31:0] sm_tdata = '0;
    logic        sm_tlast = 1'b0;
    logic        sm_tready;
    logic [15:0] io_out;
    logic [15:0] io_oeb;
    logic        word_stb;
    logic        busy;
    logic        frame_done;
    logic [7:0]  word_cnt;

    int tests = 0;
    int fails = 0;
    int stb_cnt = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    fir_yout_gpio #(.HOLD_CYCLES(H)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (wb_rst_i),
        .start_i   (start_i),
        .sm_tvalid (sm_tvalid),
        .sm_tdata  (sm_tdata),
        .sm_tlast  (sm_tlast),
        .sm_tready (sm_tready),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .word_stb  (word_stb),
        .busy      (busy),
        .frame_done(frame_done),
        .word_cnt  (word_cnt)
    );

    always @(negedge clk) begin
        if (word_stb === 1'b1)   stb_cnt++;
        if (frame_done === 1'b1) done_cnt++;
    end

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sat(input int v);
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_io"},    io_out, 16'h0000);
        chk({tag, "_oeb"},   io_oeb, 16'hFFFF);
        chk({tag, "_rdy"},   sm_tready, 1'b0);
        chk({tag, "_busy"},  busy, 1'b0);
        chk({tag, "_cnt"},   word_cnt, 8'd0);
        chk({tag, "_stb"},   word_stb, 1'b0);
        chk({tag, "_done"},  frame_done, 1'b0);
    endtask

    // Call at a negedge; leaves control at the negedge right after the handshake.
    task automatic send_word(input logic [31:0] d, input logic last, input bit rnd,
                             input logic [15:0] exp, input logic [7:0] exp_cnt,
                             input int exp_gap, input string tag);
        int waited = 0;
        int stray = 0;
        sm_tdata = d;
        sm_tlast = last;
        forever begin
            sm_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sm_tready && sm_tvalid) break;
            @(negedge clk);
            waited++;
            if (word_stb) stray++;
            if (waited > 500) break;
        end
        if (waited > 500) begin
            chk({tag, "_timeout"}, waited, 0);
            sm_tvalid = 1'b0;
            return;
        end
        @(negedge clk);
        sm_tvalid = 1'b0;
        if (exp_gap >= 0) chk({tag, "_gap"}, waited, exp_gap);
        chk({tag, "_io"},    io_out, exp);
        chk({tag, "_stb"},   word_stb, 1'b1);
        chk({tag, "_cnt"},   word_cnt, exp_cnt);
        chk({tag, "_stray"}, stray, 0);
    endtask

    task automatic open_frame(input string tag);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk({tag, "_start_io"},   io_out, SM);
        chk({tag, "_start_stb"},  word_stb, 1'b1);
        chk({tag, "_start_busy"}, busy, 1'b1);
        chk({tag, "_start_oeb"},  io_oeb, 16'h0000);
        chk({tag, "_start_cnt"},  word_cnt, 8'd0);
    endtask

    task automatic finish_frame(input int n, input int s0, input int d0, input string tag);
        int w = 0;
        do begin @(negedge clk); w++; end while (!word_stb && w < 500);
        chk({tag, "_end_gap"}, w, H);
        chk({tag, "_end_io"},  io_out, EM);
        w = 0;
        do begin @(negedge clk); w++; end while (!frame_done && w < 500);
        chk({tag, "_done_gap"}, w, H);
        chk({tag, "_done"},     frame_done, 1'b1);
        chk({tag, "_idle"},     busy, 1'b0);
        chk({tag, "_fcnt"},     word_cnt, sat(n));
        @(negedge clk);
        chk({tag, "_done_pulse"}, frame_done, 1'b0);
        chk({tag, "_io_kept"},    io_out, EM);
        chk({tag, "_nstb"},       stb_cnt - s0, n + 2);
        chk({tag, "_ndone"},      done_cnt - d0, 1);
    endtask

    task automatic run_frame(input int n, input logic [31:0] base, input bit rnd,
                             input int abort_at, input int inj_at, input string tag);
        int s0 = stb_cnt;
        int d0 = done_cnt;
        int gap = H;
        logic [31:0] d;
        open_frame(tag);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                sm_tvalid = 1'b0;
                wb_rst_i = 1'b1;
                @(negedge clk);
                chk_reset_vals({tag, "_abort"});
                wb_rst_i = 1'b0;
                return;
            end
            d = base + 32'(i);
            send_word(d, (i == n - 1), rnd, d[15:0], sat(i + 1), rnd ? -1 : gap, tag);
            gap = H;
            if (i == inj_at) begin
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
                chk({tag, "_inj_io"},   io_out, d[15:0]);
                chk({tag, "_inj_cnt"},  word_cnt, sat(i + 1));
                chk({tag, "_inj_busy"}, busy, 1'b1);
                chk({tag, "_inj_stb"},  word_stb, 1'b0);
                gap = H - 1;
            end
        end
        finish_frame(n, s0, d0, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[6];
        int   k;
        int   s0;
        int   d0;
        vt[0] = '{32'h0000_0005, 1'b0, 16'h0005};
        vt[1] = '{32'hFFFF_FFFD, 1'b0, 16'hFFFD};
        vt[2] = '{32'h0000_0007, 1'b1, 16'h0007};
        vt[3] = '{32'h0001_1234, 1'b0, 16'h1234};
        vt[4] = '{32'h7FFF_1234, 1'b0, 16'h1234};
        vt[5] = '{32'h8000_0000, 1'b1, 16'h0000};

        // reset held for three cycles
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");

        // start coincident with reset: reset wins
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk_reset_vals("rst_start");
        wb_rst_i = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // table frames
        k = 0;
        s0 = 0;
        d0 = 0;
        for (int i = 0; i < 6; i++) begin
            if (k == 0) begin
                s0 = stb_cnt;
                d0 = done_cnt;
                open_frame($sformatf("tbl%0d", i));
            end
            k++;
            send_word(vt[i].data, vt[i].last, 1'b0, vt[i].exp, 8'(k), H,
                      $sformatf("tbl%0d", i));
            if (vt[i].last) begin
                finish_frame(k, s0, d0, $sformatf("tbl%0d", i));
                k = 0;
            end
        end

        run_frame(64, 32'h0001_2345, 1'b0, -1, -1, "f64");
        run_frame(40, 32'hABCD_0100, 1'b1, -1, -1, "rnd");
        run_frame(64, 32'h0000_1000, 1'b0, 10, -1, "abort");
        run_frame(64, 32'h0000_2000, 1'b0, -1, -1, "post_abort");
        run_frame(5,  32'h0000_3000, 1'b0, -1, 1,  "inj");
        run_frame(258, 32'h0000_0000, 1'b0, -1, -1, "sat");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fir_yout_gpio.md
# fir_yout_gpio

Downstream stage of the FIR engine in the user project area. Consumes the FIR output AXI-Stream (Yn) and presents each result as a 16-bit word on the `mprj_io[31:16]` check field. Every frame is bracketed by a start marker `0xAB40` and an end marker `0xAB51`. Each word is held for a fixed number of cycles so that a GPIO-side monitor can detect every change.

## Interface
Parameters:
- `HOLD_CYCLES`, 8: cycles each word (markers included) stays on `io_out`; legal range 1..255.
- `START_MARK`, 16'hAB40: frame start marker.
- `END_MARK`, 16'hAB51: frame end marker.

Ports:
- `wb_clk_i` in 1: sole clock.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: one-cycle pulse that opens a frame; acted on only in IDLE.
- `sm_tvalid` in 1: FIR output valid.
- `sm_tdata` in 32: FIR output Yn.
- `sm_tlast` in 1: last Yn of the frame.
- `sm_tready` out 1: stream ready.
- `io_out` out 16: drives `mprj_io[31:16]`.
- `io_oeb` out 16: output enable, active-low.
- `word_stb` out 1: one-cycle pulse on every `io_out` update.
- `busy` out 1: high whenever the state is not IDLE.
- `frame_done` out 1: one-cycle pulse when END completes.
- `word_cnt` out 8: Yn words emitted in the current or last frame.

## Operation
- Reset values:
  - `io_out`=0, `io_oeb`=16'hFFFF.
  - `sm_tready`=0, `word_stb`=0, `busy`=0, `frame_done`=0, `word_cnt`=0.
  - State is IDLE, hold counter 0, FIFO (if built) empty.
- States: IDLE, START, DWAIT, DHOLD, END.
- IDLE:
  - `sm_tready`=0; `io_out` keeps its last value.
  - `start_i` → START. On entry: `io_out`=START_MARK, `io_oeb`=0 (stays 0 until reset), `word_cnt`=0, `word_stb`=1.
- START: hold counter runs for HOLD_CYCLES cycles, then → DWAIT.
- DWAIT:
  - `sm_tready`=1.
  - On handshake (`sm_tvalid & sm_tready`): `io_out`=`sm_tdata[15:0]` (truncation, no saturation), `word_cnt`+1, `word_stb`=1, `sm_tlast` latched → DHOLD.
- DHOLD:
  - `sm_tready`=0 while HOLD_CYCLES cycles elapse.
  - Afterwards: latched last → END (`io_out`=END_MARK, `word_stb`=1); otherwise → DWAIT.
- END: after HOLD_CYCLES cycles, `frame_done` pulses and the state returns to IDLE. `io_out` keeps END_MARK.
- `start_i` outside IDLE is ignored.
- `start_i` in the same cycle as `wb_rst_i`: reset wins.
- `word_cnt` saturates at 255.
- Consecutive equal Yn values produce no visible change on `io_out`. `word_stb` still pulses; monitors that need every word use `word_stb`.
- Reset mid-frame: the next cycle shows reset values, any partial frame is discarded, and the FIFO is flushed.

## Timing
- Handshake at cycle t → `io_out` and `word_stb` update at t+1.
- Each word is visible for exactly HOLD_CYCLES cycles before the next handshake is possible.
- Minimum frame length for N words: (N+2)·HOLD_CYCLES + N cycles.
- `sm_tvalid` low in DWAIT: stay in DWAIT, no strobe, `io_out` unchanged.
- `frame_done` asserts in the cycle the state returns to IDLE.
- All outputs are registered.

## Configuration
- `FIR_YOUT_FIFO_EN` defined:
  - A 4-entry FIFO (data[15:0] + last) sits between the stream and the FSM.
  - `sm_tready` = !full && state≠IDLE, so the FIR is not stalled during START, DHOLD or END.
  - DWAIT pops the FIFO instead of the stream.
  - Push at t → earliest `io_out` update at t+2.
  - Simultaneous push and pop at full cannot occur, because ready is derived from the registered full flag.
- `FIR_YOUT_FIFO_EN` undefined: no FIFO; `sm_tready` is high only in DWAIT, with the latency given above.

## Test plan
1. Reset asserted for 3 cycles → `io_out`=0, `io_oeb`=FFFF, `sm_tready`=0, `busy`=0, `word_cnt`=0.
2. HOLD_CYCLES=4, start, then Yn 5, −3, 7 (tlast on 7) → `io_out` shows AB40, 0005, FFFD, 0007, AB51, each for ≥4 cycles. Expect 5 `word_stb` pulses, 1 `frame_done`, `word_cnt`=3.
3. 64-word frame with `sm_tdata`=32'h0001_2345+i → `io_out` low 16 bits only (2345+i), `word_cnt`=64, then AB51.
4. `sm_tvalid` toggled randomly 0/1 → no missing or duplicated words, no strobe while stalled, order preserved.
5. Reset after word 10 of a 64-word frame → reset values the next cycle; a new start produces a full, correct frame.
6. `start_i` pulsed in DHOLD → ignored, with `word_cnt` and state undisturbed. With `FIR_YOUT_FIFO_EN`: `sm_tready` stays high for 4 accepted words during START, then drops until a pop.
